// File: rtl/conv_pkg.sv
// Shared types and fixed-point helpers for the streaming K x K convolver.
package conv_pkg;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} conv_state_t;

  // Wide enough for any accumulator the convolver instantiates.
  localparam int MAXW = 128;

  function automatic int acc_w(input int w, input int k);
    return 2 * w + $clog2(k * k);
  endfunction

  function automatic logic [63:0] FX_ONE(input int frac);
    return 64'd1 << frac;
  endfunction

  // Arithmetic right shift (rounds toward minus infinity), then clamp to a w-bit signed range.
  function automatic logic signed [MAXW-1:0] sat_shift(input logic signed [MAXW-1:0] acc,
                                                       input int w, input int frac);
    logic signed [MAXW-1:0] one, s, hi, lo;
    one = {{(MAXW-1){1'b0}}, 1'b1};
    s   = acc >>> frac;
    hi  = (one <<< (w - 1)) - one;
    lo  = -hi - one;
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/convolution_v4_line_buffer.sv
// One-line delay: each enabled step emits the sample written DEPTH steps earlier.
module line_buffer #(
  parameter int W     = 32,
  parameter int DEPTH = 640
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] ptr_q;

  assign dout_o = mem_q[ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (en_i) begin
      ptr_q <= (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + AW'(1);
    end
  end

  // Contents are never reset; stale data is always masked out downstream.
  always_ff @(posedge clk) begin
    if (en_i) begin
      mem_q[ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/convolution_v4.sv
// Streaming K x K "same"-size fixed-point convolver with loadable taps, zero padding,
// ready/valid backpressure and an internal end-of-frame flush of phantom zeros.
module convolution_v4
  import conv_pkg::*;
#(
  parameter int W      = 32,
  parameter int W_FRAC = 16,
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int K      = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   x_valid_i,
  output logic                   x_ready_o,
  input  logic [W-1:0]           x_data_i,
  output logic                   y_valid_o,
  input  logic                   y_ready_i,
  output logic [W-1:0]           y_data_o,
  input  logic                   coef_we_i,
  input  logic [$clog2(K*K)-1:0] coef_addr_i,
  input  logic [W-1:0]           coef_data_i,
  output logic                   busy_o
);

  localparam int H      = K / 2;
  localparam int TAPS   = K * K;
  localparam int CENTER = H * K + H;
  localparam int ACC_W  = acc_w(W, K);
  localparam int LEAD   = H * WIDTH + H;
  localparam int CW     = $clog2(WIDTH + 1);
  localparam int RW     = $clog2(HEIGHT + 1);
  localparam int PW     = $clog2(LEAD + 1);

  conv_state_t          state_q;
  logic                 alive_q;
  logic [CW-1:0]        in_col_q, out_col_q, win_col_q;
  logic [RW-1:0]        in_row_q, out_row_q, win_row_q;
  logic [PW-1:0]        ph_q;
  logic signed [W-1:0]  coef_q [TAPS];
  logic signed [W-1:0]  win_q [K][K];
  logic signed [W-1:0]  col_in [K];
  logic signed [W-1:0]  lb_out [K-1];
  logic signed [W-1:0]  tap_m [TAPS];
  logic signed [2*W-1:0] prod_q [TAPS];
  logic signed [ACC_W-1:0] sum_d, sum_q;
  logic                 win_v_q, mul_v_q, add_v_q, y_valid_q;
  logic [W-1:0]         y_data_q;
  logic                 advance, take, step, emit, last_px, last_ph;
  logic signed [W-1:0]  sample;

  assign advance   = !y_valid_q || y_ready_i;
  assign x_ready_o = alive_q && advance && (state_q != FLUSH);
  assign take      = x_valid_i && x_ready_o;
  assign step      = take || (advance && state_q == FLUSH);
  assign sample    = (state_q == FLUSH) ? '0 : x_data_i;
  assign emit      = (state_q == FLUSH) || (in_row_q > RW'(H)) ||
                     (in_row_q == RW'(H) && in_col_q >= CW'(H));
  assign last_px   = (in_col_q == CW'(WIDTH - 1)) && (in_row_q == RW'(HEIGHT - 1));
  assign last_ph   = (ph_q == PW'(LEAD - 1));
  assign busy_o    = (state_q != IDLE);
  assign y_valid_o = y_valid_q;
  assign y_data_o  = y_data_q;

  always_comb begin
    col_in[0] = sample;
    for (int k = 1; k < K; k++) col_in[k] = lb_out[k-1];
  end

  for (genvar i = 0; i < K - 1; i++) begin : g_lb
    line_buffer #(.W(W), .DEPTH(WIDTH)) u_lb (
      .clk   (clk),
      .rst   (rst),
      .en_i  (step),
      .din_i (col_in[i]),
      .dout_o(lb_out[i])
    );
  end

  // Input counters track the incoming pixel; output counters track the window centre.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      alive_q   <= 1'b0;
      in_col_q  <= '0;
      in_row_q  <= '0;
      ph_q      <= '0;
      out_col_q <= '0;
      out_row_q <= '0;
    end else begin
      alive_q <= 1'b1;
      if (step) begin
        if (emit) begin
          if (out_col_q == CW'(WIDTH - 1)) begin
            out_col_q <= '0;
            out_row_q <= (out_row_q == RW'(HEIGHT - 1)) ? '0 : out_row_q + RW'(1);
          end else begin
            out_col_q <= out_col_q + CW'(1);
          end
        end
        if (state_q == FLUSH) begin
          if (last_ph) begin
            state_q <= IDLE;
            ph_q    <= '0;
          end else begin
            ph_q <= ph_q + PW'(1);
          end
        end else if (last_px) begin
          state_q  <= FLUSH;
          in_col_q <= '0;
          in_row_q <= '0;
        end else begin
          state_q <= RUN;
          if (in_col_q == CW'(WIDTH - 1)) begin
            in_col_q <= '0;
            in_row_q <= in_row_q + RW'(1);
          end else begin
            in_col_q <= in_col_q + CW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int t = 0; t < TAPS; t++) coef_q[t] <= (t == CENTER) ? W'(FX_ONE(W_FRAC)) : '0;
    end else if (coef_we_i && state_q == IDLE) begin
      for (int t = 0; t < TAPS; t++) begin
        if (int'(coef_addr_i) == t) coef_q[t] <= coef_data_i;
      end
    end
  end

  // Tap (dr,dc) of the centre sits at win_q[H-dr][H-dc]; anything off-frame reads as zero.
  always_comb begin
    tap_m = '{default: '0};
    for (int kr = 0; kr < K; kr++) begin
      for (int kc = 0; kc < K; kc++) begin
        int r;
        int c;
        r = int'(win_row_q) + kr - H;
        c = int'(win_col_q) + kc - H;
        if (r >= 0 && r < HEIGHT && c >= 0 && c < WIDTH)
          tap_m[kr*K+kc] = win_q[K-1-kr][K-1-kc];
      end
    end
  end

  always_comb begin
    sum_d = '0;
    for (int t = 0; t < TAPS; t++) sum_d = sum_d + ACC_W'(prod_q[t]);
  end

  always_ff @(posedge clk) begin
    if (step) begin
      for (int k = 0; k < K; k++) begin
        win_q[k][0] <= col_in[k];
        for (int j = 1; j < K; j++) win_q[k][j] <= win_q[k][j-1];
      end
    end
    if (advance) begin
      for (int t = 0; t < TAPS; t++) prod_q[t] <= (2*W)'(tap_m[t]) * (2*W)'(coef_q[t]);
      sum_q <= sum_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_v_q   <= 1'b0;
      mul_v_q   <= 1'b0;
      add_v_q   <= 1'b0;
      y_valid_q <= 1'b0;
      y_data_q  <= '0;
      win_row_q <= '0;
      win_col_q <= '0;
    end else if (advance) begin
      win_v_q <= step && emit;
      if (step && emit) begin
        win_row_q <= out_row_q;
        win_col_q <= out_col_q;
      end
      mul_v_q   <= win_v_q;
      add_v_q   <= mul_v_q;
      y_valid_q <= add_v_q;
      if (add_v_q) y_data_q <= W'(sat_shift(MAXW'(sum_q), W, W_FRAC));
    end
  end

endmodule

// File: tb/tb_convolution_v4.sv
// Self-checking bench for convolution_v4 on an 8x6 frame with a 5x5 kernel.
module tb_convolution_v4;

  localparam int WD   = 8;
  localparam int HT   = 6;
  localparam int KS   = 5;
  localparam int NPIX = WD * HT;
  localparam int TAPS = KS * KS;

  logic        clk = 1'b0;
  logic        rst;
  logic        xValid, xReady, yValid, yReady, coefWe, busy;
  logic [31:0] xData, yData, coefData;
  logic [4:0]  coefAddr;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int outCount = 0;
  int accept18Cyc = 0;
  int firstValidCyc = 0;
  int readyMode = 0;
  bit firstSeen = 0;
  bit discard = 0;
  bit prevStall = 0;
  logic [31:0] prevData;
  logic [31:0] expQ[$];
  logic [31:0] img [NPIX];
  logic [31:0] ker [TAPS];

  typedef struct {
    logic [31:0] coef;
    logic [31:0] pixel;
    logic [31:0] expected;
  } vec_t;
  vec_t vecs [5];

  convolution_v4 #(.W(32), .W_FRAC(16), .WIDTH(WD), .HEIGHT(HT), .K(KS)) dut (
    .clk        (clk),
    .rst        (rst),
    .x_valid_i  (xValid),
    .x_ready_o  (xReady),
    .x_data_i   (xData),
    .y_valid_o  (yValid),
    .y_ready_i  (yReady),
    .y_data_o   (yData),
    .coef_we_i  (coefWe),
    .coef_addr_i(coefAddr),
    .coef_data_i(coefData),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (readyMode)
      0:       yReady = 1'b1;
      1:       yReady = 1'($urandom_range(0, 1));
      default: yReady = 1'b0;
    endcase
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Scoreboard side: compare every handshaken output and verify holds during stalls.
  always @(negedge clk) begin
    if (rst) begin
      prevStall = 1'b0;
    end else begin
      if (prevStall) begin
        checkOutput("stall_valid", 32'(yValid), 32'd1);
        checkOutput("stall_data", yData, prevData);
      end
      if (yValid && !firstSeen) begin
        firstSeen = 1'b1;
        firstValidCyc = cyc;
      end
      if (yValid && yReady && !discard) begin
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL extra_output actual=%h expected=none", yData);
        end else begin
          checkOutput($sformatf("y_data[%0d]", outCount), yData, expQ.pop_front());
        end
        outCount++;
      end
      prevStall = yValid && !yReady;
      prevData  = yData;
    end
  end

  task automatic writeCoef(input logic [4:0] addr, input logic [31:0] data);
    coefWe = 1'b1;
    coefAddr = addr;
    coefData = data;
    @(posedge clk);
    #1;
    coefWe = 1'b0;
  endtask

  task automatic sendPixel(input logic [31:0] d, input int idx);
    int n;
    n = 0;
    xValid = 1'b1;
    xData = d;
    forever begin
      @(negedge clk);
      if (xReady) break;
      n++;
      if (n > 1000) begin
        checks++;
        failures++;
        $display("[TB] FAIL accept_timeout actual=pixel%0d expected=accepted", idx);
        break;
      end
    end
    @(posedge clk);
    #1;
    xValid = 1'b0;
    if (idx == 18) accept18Cyc = cyc;
  endtask

  task automatic applyStimulus(input int weAt, input logic [4:0] weAddr, input logic [31:0] weData);
    outCount = 0;
    for (int i = 0; i < NPIX; i++) begin
      if (i == weAt) writeCoef(weAddr, weData);
      sendPixel(img[i], i);
      if (i == 0) checkOutput("busy_run", 32'(busy), 32'd1);
    end
  endtask

  task automatic drainFrame();
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (expQ.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain_timeout actual=%0d_left expected=0_left", expQ.size());
      expQ.delete();
    end
    repeat (8) @(posedge clk);
    #1;
    checkOutput("out_count", 32'(outCount), 32'(NPIX));
    checkOutput("busy_idle", 32'(busy), 32'd0);
  endtask

  task automatic pushModel();
    for (int r = 0; r < HT; r++) begin
      for (int c = 0; c < WD; c++) begin
        logic signed [127:0] acc, s, hiV, loV;
        acc = '0;
        for (int kr = 0; kr < KS; kr++) begin
          for (int kc = 0; kc < KS; kc++) begin
            int rr, cc;
            rr = r + kr - KS / 2;
            cc = c + kc - KS / 2;
            if (rr >= 0 && rr < HT && cc >= 0 && cc < WD)
              acc = acc + 128'(signed'(img[rr*WD+cc])) * 128'(signed'(ker[kr*KS+kc]));
          end
        end
        hiV = 128'sh7FFFFFFF;
        loV = -hiV - 1;
        s = acc >>> 16;
        if (s > hiV) s = hiV;
        else if (s < loV) s = loV;
        expQ.push_back(s[31:0]);
      end
    end
  endtask

  task automatic fillRamp();
    for (int i = 0; i < NPIX; i++) img[i] = 32'(i) << 16;
  endtask

  task automatic loadKernel();
    for (int t = 0; t < TAPS; t++) writeCoef(5'(t), ker[t]);
  endtask

  initial begin
    vecs[0] = '{coef: 32'h00010000, pixel: 32'h00010000, expected: 32'h00010000};
    vecs[1] = '{coef: 32'h00020000, pixel: 32'h00030000, expected: 32'h00060000};
    vecs[2] = '{coef: 32'h7FFF0000, pixel: 32'h00100000, expected: 32'h7FFFFFFF};
    vecs[3] = '{coef: 32'h7FFF0000, pixel: 32'hFFF00000, expected: 32'h80000000};
    vecs[4] = '{coef: 32'h00008000, pixel: 32'hFFFF0001, expected: 32'hFFFF8000};

    rst = 1'b1;
    xValid = 1'b0;
    xData = '0;
    yReady = 1'b1;
    coefWe = 1'b0;
    coefAddr = '0;
    coefData = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_x_ready", 32'(xReady), 32'd0);
    checkOutput("rst_y_valid", 32'(yValid), 32'd0);
    checkOutput("rst_y_data", yData, 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("x_ready_after_rst", 32'(xReady), 32'd1);

    // Centre-only kernels over flat frames: identity, gain, both saturation rails, floor shift.
    for (int v = 0; v < 5; v++) begin
      writeCoef(5'd12, vecs[v].coef);
      for (int i = 0; i < NPIX; i++) img[i] = vecs[v].pixel;
      for (int i = 0; i < NPIX; i++) expQ.push_back(vecs[v].expected);
      firstSeen = 1'b0;
      applyStimulus(-1, '0, '0);
      drainFrame();
      if (v == 0) checkOutput("first_latency", 32'(firstValidCyc - accept18Cyc), 32'd3);
    end

    // 3x3 ones kernel embedded in the 5x5: output counts in-frame neighbours.
    for (int kr = 1; kr <= 3; kr++)
      for (int kc = 1; kc <= 3; kc++) writeCoef(5'(kr * KS + kc), 32'h00010000);
    for (int i = 0; i < NPIX; i++) img[i] = 32'h00010000;
    for (int r = 0; r < HT; r++) begin
      for (int c = 0; c < WD; c++) begin
        int nr, nc;
        nr = 1 + ((r > 0) ? 1 : 0) + ((r < HT - 1) ? 1 : 0);
        nc = 1 + ((c > 0) ? 1 : 0) + ((c < WD - 1) ? 1 : 0);
        expQ.push_back(32'(nr * nc) << 16);
      end
    end
    applyStimulus(-1, '0, '0);
    drainFrame();

    // Full 5x5 box over a ramp, once free-flowing and once with random backpressure.
    for (int t = 0; t < TAPS; t++) ker[t] = 32'h00010000;
    loadKernel();
    fillRamp();
    pushModel();
    applyStimulus(-1, '0, '0);
    drainFrame();
    readyMode = 1;
    pushModel();
    applyStimulus(-1, '0, '0);
    drainFrame();
    readyMode = 0;

    // A write during RUN must not land; the same write in IDLE applies to the next frame.
    for (int t = 0; t < TAPS; t++) ker[t] = (t == 12) ? 32'h00010000 : 32'h0;
    loadKernel();
    pushModel();
    applyStimulus(10, 5'd0, 32'h00020000);
    drainFrame();
    writeCoef(5'd0, 32'h00020000);
    writeCoef(5'd30, 32'h12345678);
    ker[0] = 32'h00020000;
    pushModel();
    applyStimulus(-1, '0, '0);
    drainFrame();

    // Mid-frame reset while an output is stalled on the link.
    discard = 1'b1;
    readyMode = 2;
    for (int i = 0; i < 20; i++) sendPixel(img[i], i);
    repeat (6) @(posedge clk);
    #1;
    checkOutput("pre_rst_y_valid", 32'(yValid), 32'd1);
    checkOutput("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("midrst_y_valid", 32'(yValid), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_y_data", yData, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    readyMode = 0;
    discard = 1'b0;
    expQ.delete();
    @(posedge clk);
    #1;
    for (int t = 0; t < TAPS; t++) ker[t] = (t == 12) ? 32'h00010000 : 32'h0;
    pushModel();
    applyStimulus(-1, '0, '0);
    drainFrame();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/convolution_v4.md
# convolution_v4

Streaming K×K 2-D fixed-point convolution with runtime-loadable coefficients, zero-padded "same"-size output, full ready/valid backpressure and an internal end-of-frame flush. It succeeds the fixed-kernel v3 convolver in the image pipeline: it sits between a raster pixel source and downstream filters on `dstream` links, and emits exactly WIDTH×HEIGHT outputs per frame.

## Interface
- `W`, 32: signed sample and coefficient width.
- `W_FRAC`, 16: fractional bits for samples and coefficients (Q(W-W_FRAC).W_FRAC).
- `WIDTH`, 640: pixels per line.
- `HEIGHT`, 480: lines per frame.
- `K`, 5: kernel size; odd, ≥3. H = K/2.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `x`  dstream sink  N=W  input pixels, raster order, handshake on `valid & ready`.
- `y`  dstream source  N=W  output pixels, raster order.
- `coef_we`  in  1  coefficient write strobe.
- `coef_addr`  in  $clog2(K*K)  row-major tap index (addr = kr*K + kc).
- `coef_data`  in  W  signed coefficient.
- `busy`  out  1  high in RUN or FLUSH.

## Operation
- FSM states: IDLE, RUN, FLUSH. Reset → IDLE.
  - IDLE: `x.ready`=1; coefficient writes applied. First accepted pixel → RUN.
  - RUN: count accepted pixels (col, row). Accepting the last pixel (WIDTH-1, HEIGHT-1) → FLUSH.
  - FLUSH: `x.ready`=0; inject H*WIDTH+H zero phantom pixels, one per advancing cycle; after the last one → IDLE.
- Coefficient writes in RUN/FLUSH are ignored. Addresses ≥ K*K are ignored.
- Reset kernel is identity: center tap (H*K+H) = 1<<W_FRAC, all other taps 0.
- Window: K-1 line buffers plus a K×K register window. Output (r,c) is emitted when input index (r+H)*WIDTH+(c+H) is accepted, or when the matching phantom is injected.
- Out-of-frame taps (r+dr or c+dc outside the frame) are forced to 0. Masking uses the output-centre row and column counters, so there is no wrap from the previous line or frame.
- Arithmetic:
  - Products are 2W signed.
  - Sum uses ACC_W = 2W + $clog2(K*K) bits.
  - Result = sum >>> W_FRAC, arithmetic shift (truncation toward −∞).
  - Saturate to [0x80…0, 0x7F…F] of W bits.

## Timing
- Pipeline: window → multiply reg → adder-tree reg → shift/saturate reg → `y`. Output latency is 3 advancing cycles after the triggering acceptance or phantom.
- advance = !y.valid || y.ready. The whole pipeline, window and phantom counter stall when advance=0.
- `x.ready` = advance && state != FLUSH. Its value must not depend on `x.valid`.
- `y.valid` and `y.data` stay stable while `y.valid && !y.ready`.
- Continuous flow: first `y.valid` comes 3 cycles after acceptance of pixel H*WIDTH+H. Sustained rate is 1 pixel/cycle.
- Back-to-back frames: a new frame is not accepted until FLUSH completes. The first pixel of the next frame is taken in IDLE in the cycle after FLUSH ends.
- Reset values: `x.ready`=0 while `rst`=1, then 1 from the first cycle after release. `y.valid`=0, `y.data`=0, `busy`=0, counters 0, kernel identity. Line-buffer contents need no reset because masking covers them.
- `rst` asserted mid-frame: outputs return to reset values immediately (asynchronous). The partial frame is discarded and the next accepted pixel is treated as (0,0).

## Structure
- Package `conv_pkg`:
  - `conv_state_t` enum (IDLE, RUN, FLUSH).
  - `acc_w(W,K)` function.
  - `sat_shift` function (arithmetic shift plus saturation).
  - `FX_ONE(W_FRAC)` constant.
- Sub-module `line_buffer`: single-port-read/single-write RAM, depth WIDTH, width W, with shift-by-one on enable. K-1 instances.
- The top level holds the FSM, counters, window, mask, MAC pipeline and coefficient register file.

## Test plan
- Reset kernel, WIDTH=8, HEIGHT=6, K=5, all inputs 0x00010000, `y.ready`=1 → exactly 48 outputs, all 0x00010000, first one 3 cycles after input index 18.
- K=3, all 9 coefs 0x00010000, all-ones frame 8×6 → corners 0x00040000, edges 0x00060000, interior 0x00090000.
- Center coef 0x7FFF0000, input 0x00100000 → 0x7FFFFFFF. Input 0xFFF00000 → 0x80000000.
- Ramp input (pixel = index<<16), box kernel, `y.ready` pseudo-random 50% → output sequence identical to the `y.ready`=1 run, and `y.data` held stable during every stall.
- Coef write (addr 0, 0x00020000) during RUN → no effect on that frame; the same write in IDLE → takes effect on the next frame.
- `rst` pulse after 20 accepted pixels → `y.valid`=0 and `busy`=0 immediately, kernel back to identity. The following full frame is correct with 48 outputs.
